// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the write-back stage.
//   - write-back source select codes (mem_i_wb_sel)
//   - load funct3 codes (mem_i_load_funct3)
//   - write-back FSM state enum
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_CSR  = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load data formatter.
//   funct3   in  load type (LB/LH/LW/LD/LBU/LHU/LWU; 111 yields zero)
//   addr_low in  byte offset of the load within the doubleword
//   rdata    in  aligned 64-bit doubleword from data memory
//   wdata    out register write data, sign/zero-extended
module wb_load_align
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  addr_low,
    input  logic [63:0] rdata,
    output logic [63:0] wdata
);

    logic [63:0] shifted;

    // Bring the addressed byte down to bit 0 before extension.
    assign shifted = rdata >> {addr_low, 3'b000};

    always_comb begin
        wdata = '0;
        case (funct3)
            F3_LB:   wdata = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   wdata = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   wdata = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   wdata = shifted;
            F3_LBU:  wdata = {56'd0, shifted[7:0]};
            F3_LHU:  wdata = {48'd0, shifted[15:0]};
            F3_LWU:  wdata = {32'd0, shifted[31:0]};
            default: wdata = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage.
// Accepts one instruction from the memory stage when idle. Non-loads retire
// on the following cycle; loads wait in WAIT_LOAD for the data-memory
// response, then retire. Each retirement pulses write_back_o_valid for one
// cycle and bumps write_back_o_instret.
//   clk, rst                 clock, synchronous active-high reset
//   mem_i_* / mem_o_ready    instruction handshake from memory stage
//   dmem_i_rvalid/rdata      data-memory read response
//   write_back_o_*           register-file write port and retirement info
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_i_valid,
    output logic            mem_o_ready,
    input  logic [4:0]      mem_i_rd,
    input  logic            mem_i_wen,
    input  logic [1:0]      mem_i_wb_sel,
    input  logic [XLEN-1:0] mem_i_alu_result,
    input  logic [XLEN-1:0] mem_i_pc,
    input  logic [XLEN-1:0] mem_i_csr_rdata,
    input  logic [2:0]      mem_i_load_funct3,
    input  logic [2:0]      mem_i_addr_low,
    input  logic            dmem_i_rvalid,
    input  logic [XLEN-1:0] dmem_i_rdata,
    output logic [4:0]      write_back_o_rd,
    output logic [XLEN-1:0] write_back_o_reg_wdata,
    output logic            write_back_o_reg_wen,
    output logic            write_back_o_valid,
    output logic [XLEN-1:0] write_back_o_instret
);

    wb_state_e       state_q, state_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic            ld_wen_q, ld_wen_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [2:0]      ld_al_q, ld_al_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            wen_q, wen_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic [XLEN-1:0] load_wdata;
    logic [XLEN-1:0] src_wdata;
    logic            accept;

    wb_load_align u_align (
        .funct3   (ld_f3_q),
        .addr_low (ld_al_q),
        .rdata    (dmem_i_rdata),
        .wdata    (load_wdata)
    );

    assign mem_o_ready = (state_q == ST_IDLE);
    assign accept      = mem_i_valid && mem_o_ready;

    always_comb begin
        src_wdata = mem_i_alu_result;
        case (mem_i_wb_sel)
            WB_PC4:  src_wdata = mem_i_pc + XLEN'(4);
            WB_CSR:  src_wdata = mem_i_csr_rdata;
            default: src_wdata = mem_i_alu_result;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ld_rd_d   = ld_rd_q;
        ld_wen_d  = ld_wen_q;
        ld_f3_d   = ld_f3_q;
        ld_al_d   = ld_al_q;
        rd_d      = rd_q;
        wdata_d   = wdata_q;
        wen_d     = 1'b0;
        valid_d   = 1'b0;
        instret_d = instret_q;
        case (state_q)
            ST_IDLE: begin
                // dmem_i_rvalid is deliberately not looked at here: a
                // response only belongs to a load we are waiting on.
                if (accept) begin
                    ld_rd_d  = mem_i_rd;
                    ld_wen_d = mem_i_wen;
                    ld_f3_d  = mem_i_load_funct3;
                    ld_al_d  = mem_i_addr_low;
                    if (mem_i_wb_sel == WB_LOAD) begin
                        state_d = ST_WAIT_LOAD;
                    end else begin
                        wen_d     = mem_i_wen && (mem_i_rd != 5'd0);
                        valid_d   = 1'b1;
                        instret_d = instret_q + XLEN'(1);
                        // rd/wdata only move when a real write happens.
                        if (wen_d) begin
                            rd_d    = mem_i_rd;
                            wdata_d = src_wdata;
                        end
                    end
                end
            end
            ST_WAIT_LOAD: begin
                if (dmem_i_rvalid) begin
                    wen_d     = ld_wen_q && (ld_rd_q != 5'd0);
                    valid_d   = 1'b1;
                    instret_d = instret_q + XLEN'(1);
                    state_d   = ST_IDLE;
                    if (wen_d) begin
                        rd_d    = ld_rd_q;
                        wdata_d = load_wdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ld_rd_q   <= '0;
            ld_wen_q  <= 1'b0;
            ld_f3_q   <= '0;
            ld_al_q   <= '0;
            rd_q      <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            valid_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_rd_q   <= ld_rd_d;
            ld_wen_q  <= ld_wen_d;
            ld_f3_q   <= ld_f3_d;
            ld_al_q   <= ld_al_d;
            rd_q      <= rd_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
        end
    end

    assign write_back_o_rd        = rd_q;
    assign write_back_o_reg_wdata = wdata_q;
    assign write_back_o_reg_wen   = wen_q;
    assign write_back_o_valid     = valid_q;
    assign write_back_o_instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed, table-driven bench for wb_stage.
module tb_wb_stage;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_i_valid;
    logic        mem_o_ready;
    logic [4:0]  mem_i_rd;
    logic        mem_i_wen;
    logic [1:0]  mem_i_wb_sel;
    logic [63:0] mem_i_alu_result, mem_i_pc, mem_i_csr_rdata;
    logic [2:0]  mem_i_load_funct3, mem_i_addr_low;
    logic        dmem_i_rvalid;
    logic [63:0] dmem_i_rdata;
    logic [4:0]  wb_rd;
    logic [63:0] wb_wdata;
    logic        wb_wen, wb_valid;
    logic [63:0] wb_instret;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(64)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .mem_i_valid            (mem_i_valid),
        .mem_o_ready            (mem_o_ready),
        .mem_i_rd               (mem_i_rd),
        .mem_i_wen              (mem_i_wen),
        .mem_i_wb_sel           (mem_i_wb_sel),
        .mem_i_alu_result       (mem_i_alu_result),
        .mem_i_pc               (mem_i_pc),
        .mem_i_csr_rdata        (mem_i_csr_rdata),
        .mem_i_load_funct3      (mem_i_load_funct3),
        .mem_i_addr_low         (mem_i_addr_low),
        .dmem_i_rvalid          (dmem_i_rvalid),
        .dmem_i_rdata           (dmem_i_rdata),
        .write_back_o_rd        (wb_rd),
        .write_back_o_reg_wdata (wb_wdata),
        .write_back_o_reg_wen   (wb_wen),
        .write_back_o_valid     (wb_valid),
        .write_back_o_instret   (wb_instret)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] alu;
        logic [63:0] pc;
        logic [63:0] csr;
        logic [2:0]  f3;
        logic [2:0]  al;
        logic [63:0] rdata;
        logic [63:0] exp_wdata;
        logic        exp_wen;
    } vec_t;

    vec_t        vecs [14];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [4:0]  exp_rd;
    logic [63:0] exp_wdata;
    logic [63:0] exp_instret;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        mem_i_wb_sel      = v.sel;
        mem_i_rd          = v.rd;
        mem_i_wen         = v.wen;
        mem_i_alu_result  = v.alu;
        mem_i_pc          = v.pc;
        mem_i_csr_rdata   = v.csr;
        mem_i_load_funct3 = v.f3;
        mem_i_addr_low    = v.al;
        dmem_i_rdata      = v.rdata;
    endtask

    // Expected state after one retirement of v.
    task automatic retire_check(input string name, input vec_t v);
        exp_instret = exp_instret + 64'd1;
        if (v.exp_wen) begin
            exp_rd    = v.rd;
            exp_wdata = v.exp_wdata;
        end
        check({name, ".wen"},     {63'd0, wb_wen},   {63'd0, v.exp_wen});
        check({name, ".valid"},   {63'd0, wb_valid}, 64'd1);
        check({name, ".rd"},      {59'd0, wb_rd},    {59'd0, exp_rd});
        check({name, ".wdata"},   wb_wdata,          exp_wdata);
        check({name, ".instret"}, wb_instret,        exp_instret);
    endtask

    task automatic idle_check(input string name);
        check({name, ".wen0"},   {63'd0, wb_wen},   64'd0);
        check({name, ".valid0"}, {63'd0, wb_valid}, 64'd0);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        drive_vec(v);
        mem_i_valid = 1'b1;
        @(posedge clk); #1;
        mem_i_valid = 1'b0;
        if (v.sel == WB_LOAD) begin
            check({name, ".ready_wait"}, {63'd0, mem_o_ready}, 64'd0);
            idle_check({name, ".wait"});
            dmem_i_rvalid = 1'b1;
            @(posedge clk); #1;
            dmem_i_rvalid = 1'b0;
        end
        retire_check(name, v);
        check({name, ".ready"}, {63'd0, mem_o_ready}, 64'd1);
        @(posedge clk); #1;
        idle_check({name, ".after"});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd      = '0;
        exp_wdata   = '0;
        exp_instret = '0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; mem_i_valid = 1'b0; dmem_i_rvalid = 1'b0;
        v = '{2'd0, 5'd0, 1'b0, 64'd0, 64'd0, 64'd0, 3'd0, 3'd0, 64'd0, 64'd0, 1'b0};
        drive_vec(v);

        //          sel  rd     wen   alu                     pc                      csr                     f3    al    rdata                   exp_wdata               exp_wen
        vecs[0]  = '{2'd0, 5'd5,  1'b1, 64'h1234,               64'h0,                  64'h0,                  3'd0, 3'd0, 64'h0,                  64'h1234,               1'b1};
        vecs[1]  = '{2'd2, 5'd7,  1'b1, 64'h1111,               64'hFFFFFFFF_FFFFFFFC,  64'h2222,               3'd0, 3'd0, 64'h0,                  64'h0,                  1'b1};
        vecs[2]  = '{2'd3, 5'd9,  1'b1, 64'h1111,               64'h1000,               64'hDEADBEEF_CAFEF00D,  3'd0, 3'd0, 64'h0,                  64'hDEADBEEF_CAFEF00D,  1'b1};
        vecs[3]  = '{2'd0, 5'd0,  1'b1, 64'h55,                 64'h0,                  64'h0,                  3'd0, 3'd0, 64'h0,                  64'h55,                 1'b0};
        vecs[4]  = '{2'd0, 5'd3,  1'b0, 64'h77,                 64'h0,                  64'h0,                  3'd0, 3'd0, 64'h0,                  64'h77,                 1'b0};
        vecs[5]  = '{2'd1, 5'd10, 1'b1, 64'h0,                  64'h0,                  64'h0,                  3'd0, 3'd3, 64'h00000000_80FF0000,  64'hFFFFFFFF_FFFFFF80,  1'b1};
        vecs[6]  = '{2'd1, 5'd10, 1'b1, 64'h0,                  64'h0,                  64'h0,                  3'd4, 3'd3, 64'h00000000_80FF0000,  64'h80,                 1'b1};
        vecs[7]  = '{2'd1, 5'd12, 1'b1, 64'h0,                  64'h0,                  64'h0,                  3'd1, 3'd2, 64'h00000000_80FF0000,  64'hFFFFFFFF_FFFF80FF,  1'b1};
        vecs[8]  = '{2'd1, 5'd12, 1'b1, 64'h0,                  64'h0,                  64'h0,                  3'd5, 3'd2, 64'h00000000_80FF0000,  64'h80FF,               1'b1};
        vecs[9]  = '{2'd1, 5'd13, 1'b1, 64'h0,                  64'h0,                  64'h0,                  3'd2, 3'd0, 64'h12345678_87654321,  64'hFFFFFFFF_87654321,  1'b1};
        vecs[10] = '{2'd1, 5'd14, 1'b1, 64'h0,                  64'h0,                  64'h0,                  3'd6, 3'd4, 64'h12345678_87654321,  64'h12345678,           1'b1};
        vecs[11] = '{2'd1, 5'd15, 1'b1, 64'h0,                  64'h0,                  64'h0,                  3'd3, 3'd0, 64'h12345678_87654321,  64'h12345678_87654321,  1'b1};
        vecs[12] = '{2'd1, 5'd11, 1'b1, 64'h0,                  64'h0,                  64'h0,                  3'd7, 3'd0, 64'h12345678_87654321,  64'h0,                  1'b1};
        vecs[13] = '{2'd1, 5'd16, 1'b1, 64'h0,                  64'h0,                  64'h0,                  3'd2, 3'd4, 64'h80000000_00000000,  64'hFFFFFFFF_80000000,  1'b1};

        do_reset();
        check("reset.ready",   {63'd0, mem_o_ready}, 64'd1);
        check("reset.wen",     {63'd0, wb_wen},      64'd0);
        check("reset.valid",   {63'd0, wb_valid},    64'd0);
        check("reset.rd",      {59'd0, wb_rd},       64'd0);
        check("reset.wdata",   wb_wdata,             64'd0);
        check("reset.instret", wb_instret,           64'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back non-loads retire one per cycle.
        drive_vec(vecs[0]);
        mem_i_valid = 1'b1;
        @(posedge clk); #1;
        retire_check("b2b0", vecs[0]);
        check("b2b0.ready", {63'd0, mem_o_ready}, 64'd1);
        drive_vec(vecs[2]);
        @(posedge clk); #1;
        mem_i_valid = 1'b0;
        retire_check("b2b1", vecs[2]);
        @(posedge clk); #1;
        idle_check("b2b.after");

        // Load with rvalid in the accept cycle (ignored), then 3 cycles delay.
        drive_vec(vecs[9]);
        mem_i_valid   = 1'b1;
        dmem_i_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_i_valid   = 1'b0;
        dmem_i_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("dly%0d.ready", c), {63'd0, mem_o_ready}, 64'd0);
            idle_check($sformatf("dly%0d", c));
            check($sformatf("dly%0d.instret", c), wb_instret, exp_instret);
            @(posedge clk); #1;
        end
        check("dly3.ready", {63'd0, mem_o_ready}, 64'd0);
        dmem_i_rvalid = 1'b1;
        @(posedge clk); #1;
        dmem_i_rvalid = 1'b0;
        retire_check("dly.ret", vecs[9]);
        @(posedge clk); #1;
        idle_check("dly.after");
        check("dly.instret_once", wb_instret, exp_instret);

        // Reset in WAIT_LOAD abandons the load; stray rvalid later is ignored.
        do_reset();
        drive_vec(vecs[11]);
        mem_i_valid = 1'b1;
        @(posedge clk); #1;
        mem_i_valid = 1'b0;
        check("rstw.ready_wait", {63'd0, mem_o_ready}, 64'd0);
        rst = 1'b1;
        dmem_i_rvalid = 1'b1;   // same edge as reset: reset wins
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstw.ready", {63'd0, mem_o_ready}, 64'd1);
        idle_check("rstw.edge");
        @(posedge clk); #1;     // stray rvalid while idle
        dmem_i_rvalid = 1'b0;
        idle_check("rstw.stray");
        check("rstw.instret", wb_instret, 64'd0);
        check("rstw.wdata",   wb_wdata,   64'd0);
        check("rstw.ready2",  {63'd0, mem_o_ready}, 64'd1);

        // Reset beats an accept on the same edge.
        drive_vec(vecs[0]);
        mem_i_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_i_valid = 1'b0;
        idle_check("rsta");
        check("rsta.instret", wb_instret, 64'd0);
        check("rsta.rd", {59'd0, wb_rd}, 64'd0);

        // instret wraps from all-ones to zero.
        force dut.instret_q = 64'hFFFFFFFF_FFFFFFFF;
        @(posedge clk); #1;
        release dut.instret_q;
        exp_instret = 64'hFFFFFFFF_FFFFFFFF;
        check("wrap.pre", wb_instret, exp_instret);
        run_vec("wrap", vecs[0]);
        check("wrap.zero", wb_instret, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
